muldiv_sequencer: RTL and testbench

//   Multi-cycle multiply/divide sequencer owning the HI/LO register pair, placed in the E stage

---
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair, with the D-stage stall request.
// Optional build macro MD_CANCEL_EN adds the md_cancel flush input.
module muldiv_sequencer #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_mdop,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
`ifdef MD_CANCEL_EN
    ,
    input  logic        md_cancel
`endif
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [2:0]    op_q;

    logic          cancel;
    logic          is_div;
    logic          div_zero;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [63:0]   acc;
    logic          neg_a;
    logic          neg_b;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic [31:0]   div_hi;
    logic [31:0]   div_lo;
    logic [63:0]   result;

`ifdef MD_CANCEL_EN
    assign cancel = md_cancel;
`else
    assign cancel = 1'b0;
`endif

    assign md_stall = d_mdop & (busy | start);
    assign is_div   = (op_q[2:1] == 2'b01);
    assign div_zero = is_div && (b_q == '0);

    // Signed division via magnitudes so the 0x80000000 / -1 overflow case needs no special path.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        acc    = {hi, lo};
        neg_a  = op_q[0] & a_q[31];
        neg_b  = op_q[0] & b_q[31];
        mag_a  = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b  = (b_q == '0) ? 32'd1 : (neg_b ? (~b_q + 32'd1) : b_q);
        quo    = mag_a / mag_b;
        rem    = mag_a % mag_b;
        div_lo = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
        div_hi = neg_a ? (~rem + 32'd1) : rem;
        result = acc;
        case (op_q)
            3'b000:         result = prod_u;
            3'b001:         result = prod_s;
            3'b010, 3'b011: result = {div_hi, div_lo};
            3'b100:         result = acc + prod_s;
            3'b101:         result = acc - prod_s;
            3'b110:         result = acc + prod_u;
            3'b111:         result = acc - prod_u;
            default:        result = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        a_q     <= rs_val;
                        b_q     <= rt_val;
                        op_q    <= md_op;
                        counter <= (md_op[2:1] == 2'b01) ? DIV_CNT : MUL_CNT;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (!start && !cancel) begin
                        if (mthi) hi <= rs_val;
                        if (mtlo) lo <= rs_val;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        counter <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (counter == ONE_CNT) begin
                        if (!div_zero) begin
                            hi <= result[63:32];
                            lo <= result[31:0];
                        end
                        counter <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - ONE_CNT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random ops checked against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_mdop;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;
`ifdef MD_CANCEL_EN
    logic        md_cancel;
`endif

    muldiv_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_op    (md_op),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_mdop   (d_mdop),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
`ifdef MD_CANCEL_EN
        ,
        .md_cancel(md_cancel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-operation arithmetic on 64-bit integers.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l,
                                   output logic [31:0] nh, output logic [31:0] nl);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          m;
        logic [63:0]     acc;
        logic [63:0]     r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {h, l};
        r   = acc;
        case (op)
            3'd0: r = ua * ub;
            3'd1: r = sa * sb;
            3'd2: if (b != 0) r = {a % b, a / b};
            3'd3: if (b != 0) begin
                q = sa / sb;
                m = sa % sb;
                r = {m[31:0], q[31:0]};
            end
            3'd4: r = acc + sa * sb;
            3'd5: r = acc - sa * sb;
            3'd6: r = acc + ua * ub;
            default: r = acc - ua * ub;
        endcase
        nh = r[63:32];
        nl = r[31:0];
    endfunction

    // Monitor: each busy high->low transition is one completed (or cancelled) operation.
    initial begin : monitor
        int   cnt;
        logic prev;
        exp_t e;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                end else if (prev) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=busy_drop required=none t=%0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("op_hi", hi, e.hi);
                        check("op_lo", lo, e.lo);
                        check("busy_cycles", 32'(cnt), 32'(e.cyc));
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d, input bit inject, input bit mt_with_start);
        logic [31:0] nh;
        logic [31:0] nl;
        int          n;
        exp_t        e;
        n = (op[2:1] == 2'b01) ? DIV_N : MUL_N;
        ref_op(op, a, b, m_hi, m_lo, nh, nl);
        e.hi = nh;
        e.lo = nl;
        e.cyc = n;
        sb_q.push_back(e);
        m_hi = nh;
        m_lo = nl;
        @(posedge clk); #1;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_mdop = d;
        mthi = mt_with_start; mtlo = mt_with_start;
        @(negedge clk);
        check("stall_launch", {31'd0, md_stall}, {31'd0, d});
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        for (int i = 0; i < n; i++) begin
            if (inject && i == 1) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; md_op = 3'($urandom);
            end
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 32'd1);
            check("stall_run", {31'd0, md_stall}, {31'd0, d});
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        end
        @(negedge clk);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("stall_done", {31'd0, md_stall}, 32'd0);
        d_mdop = 1'b0;
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] v);
        @(posedge clk); #1;
        mthi = wh; mtlo = wl; rs_val = v;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        @(negedge clk);
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset_n = 1'b0; start = 1'b0; md_op = '0; mthi = 1'b0; mtlo = 1'b0;
        rs_val = '0; rt_val = '0; d_mdop = 1'b0;
`ifdef MD_CANCEL_EN
        md_cancel = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, md_stall}, 32'd0);

        launch(3'b001, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 1'b0);
        check("t1_hi", hi, 32'hFFFFFFFF);
        check("t1_lo", lo, 32'hFFFFFFF1);
        launch(3'b010, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        check("t2_divu_hi", hi, 32'd1);
        check("t2_divu_lo", lo, 32'd3);
        launch(3'b011, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check("t2_div_hi", hi, 32'hFFFFFFFF);
        check("t2_div_lo", lo, 32'hFFFFFFFD);

        mt_write(1'b1, 1'b0, 32'h1);
        mt_write(1'b0, 1'b1, 32'hFFFFFFFF);
        launch(3'b110, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        check("t3_maddu_hi", hi, 32'd2);
        check("t3_maddu_lo", lo, 32'd0);
        launch(3'b101, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        check("t3_msub_hi", hi, 32'd1);
        check("t3_msub_lo", lo, 32'hFFFFFFFA);

        mt_write(1'b1, 1'b0, 32'hA);
        mt_write(1'b0, 1'b1, 32'hB);
        launch(3'b011, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t4_dz_hi", hi, 32'hA);
        check("t4_dz_lo", lo, 32'hB);

        launch(3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        check("ovf_hi", hi, 32'd0);
        check("ovf_lo", lo, 32'h80000000);

        mt_write(1'b1, 1'b1, 32'h55AA55AA);
        launch(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) begin
                mt_write(1'($urandom), 1'($urandom), $urandom);
            end else begin
                op = 3'($urandom);
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 7))
                    0: b = '0;
                    1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                    2: b = 32'($urandom_range(1, 9));
                    default: ;
                endcase
                launch(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        // Asynchronous reset in RUN cycle 3 of a mult.
        mt_write(1'b1, 1'b1, 32'h12345678);
        @(posedge clk); #1;
        start = 1'b1; md_op = 3'b001; rs_val = 32'd9; rt_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        launch(3'b100, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0, 1'b0);

`ifdef MD_CANCEL_EN
        begin
            exp_t e;
            mt_write(1'b1, 1'b1, 32'hC0FFEE00);
            e.hi = m_hi;
            e.lo = m_lo;
            e.cyc = 2;
            sb_q.push_back(e);
            @(posedge clk); #1;
            start = 1'b1; md_op = 3'b001; rs_val = 32'd3; rt_val = 32'd4;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            md_cancel = 1'b1;
            @(posedge clk); #1;
            md_cancel = 1'b0;
            @(negedge clk);
            check("cancel_busy", {31'd0, busy}, 32'd0);
            check("cancel_hi", hi, m_hi);
            @(posedge clk); #1;
            start = 1'b1; md_cancel = 1'b1; md_op = 3'b000;
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h0BAD0BAD;
            @(posedge clk); #1;
            mthi = 1'b0; mtlo = 1'b0; md_cancel = 1'b0;
            @(negedge clk);
            check("cancel_start_busy", {31'd0, busy}, 32'd0);
            check("cancel_mt_lo", lo, m_lo);
        end
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
